cache_fill_sequencer: RTL and testbench
=======================================

// Module: cache_fill_sequencer
// PURPOSE
//  Sits between the direct-mapped cache's SDRAM port and the 16-bit SDRAM controller.
//  Takes one line-fill request and fetches the 8-word line as 16 halfwords in linear order.
//  Assembles the halfwords into 32-bit words and stores the whole line.
//  Then replays the line to the cache as 8 back-to-back words, critical word first, with wrap.
// PARAMETERS
//  LINEBITS      3  log2(words per line); fixed at 3 for the cache fill FSM (8 words)
//  LOW_HALF_1ST  1  1: first halfword of each pair is bits[15:0]; 0: bits[31:16]
// PORTS
//  clk             in   1   system clock
//  reset           in   1   asynchronous, active-low reset
//  cache_req       in   1   line-fill request from cache; level, sampled in IDLE
//  cache_addr      in   32  miss address; [4:2] = critical word
//  cache_fill      out  1   high for 1 cycle with critical word; next 7 words follow
//  cache_data      out  32  fill data word
//  sdram_req       out  1   burst request to controller
//  sdram_addr      out  32  line base address: {cache_addr[31:5],5'b0}
//  sdram_ack       in   1   controller accepted request (1-cycle pulse)
//  sdram_strobe    in   1   halfword valid on sdram_data; may have gaps
//  sdram_data      in   16  read halfword
//  busy            out  1   high whenever state != IDLE
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state = IDLE; sdram_req = 0; cache_fill = 0; busy = 0.
//   - cache_data = 0; sdram_addr = 0; all counters = 0.
//  IDLE:
//   - cache_req = 1 -> latch cache_addr, set sdram_req = 1, go to REQ.
//   - sdram_addr is registered from the latched address.
//  REQ:
//   - Hold sdram_req until sdram_ack, then clear it.
//   - Strobes arriving on the ack cycle or later are counted.
//   - Go to COLLECT on ack.
//  COLLECT:
//   - 4-bit halfword counter hcnt increments on each sdram_strobe.
//   - Word index = hcnt[3:1]; the half is chosen by hcnt[0] and LOW_HALF_1ST.
//   - Write the half into an 8x32 line buffer with a per-half write enable.
//   - The strobe with hcnt == 15 completes the line; go to STREAM on the next cycle.
//   - Gaps in sdram_strobe of any length are tolerated. There is no timeout.
//  STREAM:
//   - 3-bit counter k runs 0..7, one word per cycle, no gaps.
//   - cache_data = buf[(crit + k) mod 8], with crit = latched addr[4:2].
//   - Index addition wraps modulo 8.
//   - cache_fill = 1 only at k = 0 (registered, aligned with the critical word).
//   - cache_data holds the last word for one extra cycle, then returns to IDLE.
//  Latency:
//   - Last halfword strobe -> cache_fill: 2 cycles.
//   - Request accepted -> sdram_req high: 1 cycle.
//  Boundaries:
//   - cache_req changing or dropping after IDLE is ignored; the line always completes.
//   - A new cache_req is accepted only in IDLE. A request held high across the return
//     to IDLE is treated as a new request.
//   - sdram_strobe in IDLE or STREAM is ignored (no buffer write).
//   - crit = 7: order 7,0,1,...,6. crit = 0: order 0..7.
//   - Reset mid-burst: all state abandoned; any later controller strobes are ignored in IDLE.
// STRUCTURE
//  Shared package/header (cache_pkg):
//   - State localparams IDLE=0, REQ=1, COLLECT=2, STREAM=3.
//   - LINEBITS, and an address split helper (line base, word index).
//  Sub-module fill_line_buf:
//   - 8x32 register file, two 16-bit write enables.
//   - Async read at a 3-bit index.
//   - No reset on storage (contents are don't-care until written).
//  Top level: FSM, hcnt/k counters, address latch, output registers.
// TESTING
//  1. Address 0x0000_1234 (crit = 5); halfwords 0x0000..0x000F, no gaps ->
//     sdram_addr = 0x0000_1220; fill words 0x000B000A, 0x000D000C, 0x000F000E,
//     0x00010000, ..., 0x00090008.
//  2. crit = 0; random gaps of 0-5 cycles between strobes -> words 0..7 in linear
//     order; cache_fill exactly once, 2 cycles after the last strobe.
//  3. sdram_ack delayed 10 cycles -> sdram_req held 10 cycles, cleared the cycle
//     after ack; no strobe was counted before ack.
//  4. cache_req dropped during COLLECT -> the line still streams all 8 words;
//     busy low the cycle after the final hold.
//  5. Reset asserted at hcnt = 6, then 10 stray strobes -> outputs return to reset
//     values immediately; no cache_fill; a new request works normally.
//  6. LOW_HALF_1ST = 0 build, same stimulus as test 1 -> critical word 0x000A000B.

Source files
------------

// File: rtl/cache_fill_sequencer_pkg.sv
// Shared definitions for the cache line-fill sequencer: line geometry,
// FSM state encoding and address split helpers.
package cache_fill_sequencer_pkg;

   // log2(words per line); the cache fill FSM expects 8-word lines
   localparam int LINEBITS   = 3;
   localparam int LINE_WORDS = 1 << LINEBITS;
   // Halfword counter covers two halves per word
   localparam int HCNT_W     = LINEBITS + 1;
   // Byte-offset bits inside one line (word index plus byte-in-word)
   localparam int OFFS_W     = LINEBITS + 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      COLLECT = 2'd2,
      STREAM  = 2'd3
   } fill_state_t;

   // Line-aligned base address of the line containing addr
   function automatic logic [31:0] line_base(input logic [31:0] addr);
      return {addr[31:OFFS_W], {OFFS_W{1'b0}}};
   endfunction

   // Index of the addressed (critical) word within its line
   function automatic logic [LINEBITS-1:0] word_index(input logic [31:0] addr);
      return addr[OFFS_W-1:2];
   endfunction

endpackage

// File: rtl/cache_fill_sequencer_if.sv
// Bundle of the cache-side and SDRAM-side signals of the fill sequencer.
// The sequencer connects through the slave modport; whatever drives the
// cache request and the SDRAM controller responses uses the master modport.
interface cache_fill_sequencer_if;

   // cache side
   logic        cache_req;
   logic [31:0] cache_addr;
   logic        cache_fill;
   logic [31:0] cache_data;
   // SDRAM controller side
   logic        sdram_req;
   logic [31:0] sdram_addr;
   logic        sdram_ack;
   logic        sdram_strobe;
   logic [15:0] sdram_data;
   // status
   logic        busy;

   modport slave (
      input  cache_req,
      input  cache_addr,
      output cache_fill,
      output cache_data,
      output sdram_req,
      output sdram_addr,
      input  sdram_ack,
      input  sdram_strobe,
      input  sdram_data,
      output busy
   );

   modport master (
      output cache_req,
      output cache_addr,
      input  cache_fill,
      input  cache_data,
      input  sdram_req,
      input  sdram_addr,
      output sdram_ack,
      output sdram_strobe,
      output sdram_data,
      input  busy
   );

endinterface

// File: rtl/cache_fill_sequencer_fill_line_buf.sv
// One-line buffer for the fill sequencer: LINE_WORDS x 32 registers,
// written a halfword at a time, read combinationally at a word index.
// Storage has no reset; every word is fully written before it is read.
module fill_line_buf
   import cache_fill_sequencer_pkg::*;
(
   input  logic                clk,
   input  logic                we_lo,
   input  logic                we_hi,
   input  logic [LINEBITS-1:0] wr_idx,
   input  logic [15:0]         wr_half,
   input  logic [LINEBITS-1:0] rd_idx,
   output logic [31:0]         rd_data
);

   logic [LINE_WORDS-1:0][31:0] words;

   genvar gi;
   generate
      for (gi = 0; gi < LINE_WORDS; gi++) begin : g_word
         logic [15:0] lo_reg;
         logic [15:0] hi_reg;
         logic        sel;

         assign sel = (wr_idx == LINEBITS'(gi));

         // Capture whichever half of this word the current strobe addresses
         always_ff @(posedge clk) begin
            if (we_lo && sel) lo_reg <= wr_half;
            if (we_hi && sel) hi_reg <= wr_half;
         end

         assign words[gi] = {hi_reg, lo_reg};
      end
   endgenerate

   assign rd_data = words[rd_idx];

endmodule

// File: rtl/cache_fill_sequencer.sv
// Cache line-fill sequencer. Accepts one miss request from the cache,
// fetches the line from the 16-bit SDRAM controller as 16 halfwords in
// linear order, assembles them into 32-bit words, then replays the line
// to the cache as 8 back-to-back words starting at the critical word
// and wrapping around the line.
module cache_fill_sequencer
   import cache_fill_sequencer_pkg::*;
#(
   parameter bit LOW_HALF_1ST = 1'b1  // 1: first halfword of a pair is bits [15:0]
)
(
   input  logic                 clk,
   input  logic                 reset,   // asynchronous, active low
   cache_fill_sequencer_if.slave bus
);

   fill_state_t          state_reg,      state_next;
   logic [LINEBITS-1:0]  crit_reg,       crit_next;
   logic [31:0]          sdram_addr_reg, sdram_addr_next;
   logic                 sdram_req_reg,  sdram_req_next;
   logic [HCNT_W-1:0]    hcnt_reg,       hcnt_next;
   logic [LINEBITS-1:0]  k_reg,          k_next;
   // 0: streaming words; 1: last word on the bus; 2: extra hold cycle
   logic [1:0]           tail_reg,       tail_next;
   logic [31:0]          cache_data_reg, cache_data_next;
   logic                 cache_fill_reg, cache_fill_next;

   logic                 half_wr;
   logic                 buf_we_lo;
   logic                 buf_we_hi;
   logic [LINEBITS-1:0]  buf_rd_idx;
   logic [31:0]          buf_rd_data;

   // Even/odd halfword of a pair lands in the low or high half depending
   // on the controller's halfword order.
   assign buf_we_lo  = half_wr && (hcnt_reg[0] != LOW_HALF_1ST);
   assign buf_we_hi  = half_wr && (hcnt_reg[0] == LOW_HALF_1ST);
   // Critical-word-first order; the 3-bit sum wraps around the line
   assign buf_rd_idx = crit_reg + k_reg;

   fill_line_buf u_line_buf (
      .clk     (clk),
      .we_lo   (buf_we_lo),
      .we_hi   (buf_we_hi),
      .wr_idx  (hcnt_reg[HCNT_W-1:1]),
      .wr_half (bus.sdram_data),
      .rd_idx  (buf_rd_idx),
      .rd_data (buf_rd_data)
   );

   // Next-state, counter and output-register logic
   always_comb begin
      state_next      = state_reg;
      crit_next       = crit_reg;
      sdram_addr_next = sdram_addr_reg;
      sdram_req_next  = sdram_req_reg;
      hcnt_next       = hcnt_reg;
      k_next          = k_reg;
      tail_next       = tail_reg;
      cache_data_next = cache_data_reg;
      cache_fill_next = 1'b0;
      half_wr         = 1'b0;

      case (state_reg)
         IDLE: begin
            // Only here is a new request accepted; strobes are ignored
            if (bus.cache_req) begin
               crit_next       = word_index(bus.cache_addr);
               sdram_addr_next = line_base(bus.cache_addr);
               sdram_req_next  = 1'b1;
               hcnt_next       = '0;
               k_next          = '0;
               tail_next       = 2'd0;
               state_next      = REQ;
            end
         end

         REQ: begin
            // A halfword may already arrive on the ack cycle
            if (bus.sdram_ack) begin
               sdram_req_next = 1'b0;
               state_next     = COLLECT;
               if (bus.sdram_strobe) begin
                  half_wr   = 1'b1;
                  hcnt_next = hcnt_reg + 4'd1;
               end
            end
         end

         COLLECT: begin
            // Gaps between strobes are simply waited out
            if (bus.sdram_strobe) begin
               half_wr   = 1'b1;
               hcnt_next = hcnt_reg + 4'd1;
               if (hcnt_reg == '1) begin
                  state_next = STREAM;
               end
            end
         end

         STREAM: begin
            if (tail_reg == 2'd0) begin
               cache_data_next = buf_rd_data;
               cache_fill_next = (k_reg == '0);
               k_next          = k_reg + 3'd1;
               if (k_reg == '1) begin
                  tail_next = 2'd1;
               end
            end else if (tail_reg == 2'd1) begin
               tail_next = 2'd2;
            end else begin
               tail_next  = 2'd0;
               state_next = IDLE;
            end
         end

         default: state_next = IDLE;
      endcase
   end

   // State and output registers; reset abandons any burst in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg      <= IDLE;
         crit_reg       <= '0;
         sdram_addr_reg <= '0;
         sdram_req_reg  <= 1'b0;
         hcnt_reg       <= '0;
         k_reg          <= '0;
         tail_reg       <= 2'd0;
         cache_data_reg <= '0;
         cache_fill_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         crit_reg       <= crit_next;
         sdram_addr_reg <= sdram_addr_next;
         sdram_req_reg  <= sdram_req_next;
         hcnt_reg       <= hcnt_next;
         k_reg          <= k_next;
         tail_reg       <= tail_next;
         cache_data_reg <= cache_data_next;
         cache_fill_reg <= cache_fill_next;
      end
   end

   assign bus.sdram_req  = sdram_req_reg;
   assign bus.sdram_addr = sdram_addr_reg;
   assign bus.cache_fill = cache_fill_reg;
   assign bus.cache_data = cache_data_reg;
   assign bus.busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_cache_fill_sequencer.sv
// Directed bench for cache_fill_sequencer. Two builds run side by side on
// the same stimulus (low-half-first and high-half-first); the expected
// fill words of the low-half-first build go through a scoreboard queue.
module tb_cache_fill_sequencer;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic        cache_req    = 1'b0;
   logic [31:0] cache_addr   = '0;
   logic        sdram_ack    = 1'b0;
   logic        sdram_strobe = 1'b0;
   logic [15:0] sdram_data   = '0;

   cache_fill_sequencer_if if0 ();
   cache_fill_sequencer_if if1 ();

   assign if0.cache_req    = cache_req;
   assign if0.cache_addr   = cache_addr;
   assign if0.sdram_ack    = sdram_ack;
   assign if0.sdram_strobe = sdram_strobe;
   assign if0.sdram_data   = sdram_data;
   assign if1.cache_req    = cache_req;
   assign if1.cache_addr   = cache_addr;
   assign if1.sdram_ack    = sdram_ack;
   assign if1.sdram_strobe = sdram_strobe;
   assign if1.sdram_data   = sdram_data;

   cache_fill_sequencer #(.LOW_HALF_1ST(1'b1)) dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (if0)
   );

   cache_fill_sequencer #(.LOW_HALF_1ST(1'b0)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (if1)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   int          fill_count = 0;
   int          mon_left = 0;
   logic [31:0] exp_q [$];
   logic [15:0] hw [16];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard consumer: every cache_fill starts an 8-word line
   always @(negedge clk) begin
      if (if0.cache_fill === 1'b1) begin
         fill_count++;
         if (mon_left != 0) check("mon_fill_inside_line", mon_left, 0);
         mon_left = 8;
      end
      if (mon_left > 0) begin
         if (exp_q.size() == 0) check("mon_queue_nonempty", 32'(exp_q.size()), 32'd8);
         else check("mon_word", if0.cache_data, exp_q.pop_front());
         mon_left--;
      end
   end

   // One complete line fill, with the scoreboard loaded up front
   task automatic run_line(input string tag, input logic [31:0] addr, input int ack_cycles,
                           input bit junk_pre_ack, input int max_gap, input bit hold_req,
                           input bit junk_stream, input bit chk_alt, input logic [31:0] alt_word);
      int          lat;
      int          fills_before;
      int          crit;
      int          last_w;
      int          gap;
      logic [31:0] last_word;
      crit         = int'(addr[4:2]);
      last_w       = (crit + 7) % 8;
      last_word    = {hw[2*last_w+1], hw[2*last_w]};
      fills_before = fill_count;
      for (int j = 0; j < 8; j++) begin
         int w;
         w = (crit + j) % 8;
         exp_q.push_back({hw[2*w+1], hw[2*w]});
      end

      cache_addr = addr;
      cache_req  = 1'b1;
      tick();
      check({tag, " req_rise"}, 32'(if0.sdram_req), 32'd1);
      check({tag, " sdram_addr"}, if0.sdram_addr, {addr[31:5], 5'b0});
      check({tag, " busy_high"}, 32'(if0.busy), 32'd1);
      if (!hold_req) cache_req = 1'b0;

      for (int i = 1; i < ack_cycles; i++) begin
         if (junk_pre_ack) begin
            sdram_strobe = 1'b1;
            sdram_data   = 16'hDEAD;
         end
         tick();
         check({tag, " req_hold"}, 32'(if0.sdram_req), 32'd1);
      end

      sdram_ack    = 1'b1;
      sdram_strobe = 1'b1;
      sdram_data   = hw[0];
      tick();
      sdram_ack    = 1'b0;
      sdram_strobe = 1'b0;
      check({tag, " req_clear"}, 32'(if0.sdram_req), 32'd0);

      for (int i = 1; i < 16; i++) begin
         gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         for (int g = 0; g < gap; g++) tick();
         if (hold_req && i == 6) cache_req = 1'b0;
         sdram_strobe = 1'b1;
         sdram_data   = hw[i];
         tick();
         sdram_strobe = 1'b0;
      end

      sdram_strobe = junk_stream;
      sdram_data   = 16'hBAD0;
      lat = 1;
      while (if0.cache_fill !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      check({tag, " fill_latency"}, lat, 32'd2);
      if (chk_alt) begin
         check({tag, " alt_fill"}, 32'(if1.cache_fill), 32'd1);
         check({tag, " alt_crit_word"}, if1.cache_data, alt_word);
      end
      repeat (8) tick();
      check({tag, " hold_word"}, if0.cache_data, last_word);
      check({tag, " busy_in_hold"}, 32'(if0.busy), 32'd1);
      sdram_strobe = 1'b0;
      tick();
      check({tag, " busy_low"}, 32'(if0.busy), 32'd0);
      check({tag, " fill_once"}, fill_count - fills_before, 32'd1);
      check({tag, " queue_drained"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int fills_before;

      // Reset values
      tick();
      tick();
      check("rst sdram_req", 32'(if0.sdram_req), 32'd0);
      check("rst cache_fill", 32'(if0.cache_fill), 32'd0);
      check("rst busy", 32'(if0.busy), 32'd0);
      check("rst cache_data", if0.cache_data, 32'd0);
      check("rst sdram_addr", if0.sdram_addr, 32'd0);
      reset = 1'b1;
      tick();

      // T1/T6: crit = 5, halfwords 0..15 back to back; other build gets swapped halves
      for (int i = 0; i < 16; i++) hw[i] = 16'(i);
      run_line("T1", 32'h0000_1234, 1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 32'h000A_000B);

      // T2: crit = 0, random gaps of 0-5 cycles
      for (int i = 0; i < 16; i++) hw[i] = 16'($urandom);
      run_line("T2", 32'h8000_0040, 1, 1'b0, 5, 1'b0, 1'b0, 1'b0, 32'h0);

      // T3: crit = 7, ack after 10 cycles with stray strobes before it
      for (int i = 0; i < 16; i++) hw[i] = 16'($urandom);
      run_line("T3", 32'h0000_ABDC, 10, 1'b1, 2, 1'b0, 1'b0, 1'b0, 32'h0);

      // T4: cache_req held then dropped mid-collect, strobes during stream
      for (int i = 0; i < 16; i++) hw[i] = 16'($urandom);
      run_line("T4", 32'hFFFF_FFE8, 3, 1'b0, 1, 1'b1, 1'b1, 1'b0, 32'h0);

      // T5: reset after six halfwords, then stray strobes in IDLE
      fills_before = fill_count;
      cache_addr   = 32'h1234_5678;
      cache_req    = 1'b1;
      tick();
      cache_req    = 1'b0;
      sdram_ack    = 1'b1;
      sdram_strobe = 1'b1;
      sdram_data   = 16'h1111;
      tick();
      sdram_ack    = 1'b0;
      for (int i = 1; i < 6; i++) begin
         sdram_data = 16'(16'h1111 * (i + 1));
         tick();
      end
      sdram_strobe = 1'b0;
      reset = 1'b0;
      #1;
      check("T5 rst sdram_req", 32'(if0.sdram_req), 32'd0);
      check("T5 rst cache_fill", 32'(if0.cache_fill), 32'd0);
      check("T5 rst busy", 32'(if0.busy), 32'd0);
      check("T5 rst cache_data", if0.cache_data, 32'd0);
      check("T5 rst sdram_addr", if0.sdram_addr, 32'd0);
      tick();
      tick();
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         sdram_strobe = 1'b1;
         sdram_data   = 16'hE000 + 16'(i);
         tick();
      end
      sdram_strobe = 1'b0;
      tick();
      check("T5 idle busy", 32'(if0.busy), 32'd0);
      check("T5 idle sdram_req", 32'(if0.sdram_req), 32'd0);
      check("T5 no_fill", fill_count - fills_before, 32'd0);

      // T5b: a fresh request after the aborted burst
      for (int i = 0; i < 16; i++) hw[i] = 16'($urandom);
      run_line("T5b", 32'h0000_0004, 2, 1'b0, 0, 1'b0, 1'b0, 1'b0, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global time bound in case the design stalls in an unexpected way
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
